// File: rtl/timestamp_capture_311.sv
// timestamp_capture_311
//
// Captures the value of a free-running up counter whenever an asynchronous
// event input shows a rising edge, and queues it in a small first-word-fall-
// through FIFO that a host drains with a read-enable handshake. Captures lost
// to a full FIFO raise a sticky overflow flag.
//
// All state updates on the falling edge of clk_311, the same edge as the
// counter, so count_in_311 is sampled before the counter's own update.
//
// Ports:
//   clk_311         single clock, falling-edge active
//   reset_311       synchronous active-high reset
//   count_in_311    counter value to timestamp with
//   event_in_311    asynchronous event; rising edge requests a capture
//   rd_en_311       pop request, honoured only while ts_valid_311 = 1
//   clr_ovf_311     clears overflow_311 (a same-cycle overflow wins)
//   ts_out_311      FIFO head, 0 while empty
//   ts_valid_311    FIFO non-empty
//   fifo_level_311  stored entry count, 0..DEPTH
//   overflow_311    sticky: a capture was dropped on a full FIFO

module timestamp_capture_311 #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk_311,
    input  logic                     reset_311,
    input  logic [WIDTH-1:0]         count_in_311,
    input  logic                     event_in_311,
    input  logic                     rd_en_311,
    input  logic                     clr_ovf_311,
    output logic [WIDTH-1:0]         ts_out_311,
    output logic                     ts_valid_311,
    output logic [$clog2(DEPTH):0]   fifo_level_311,
    output logic                     overflow_311
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]   FullLevel = DEPTH[PtrW:0];
    localparam logic [PtrW:0]   LevelOne  = 1;
    localparam logic [PtrW-1:0] PtrOne    = 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   strobe;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    level_q;
    logic             ovf_q;

    logic empty;
    logic full;
    logic do_read;
    logic do_write;
    logic drop;

    // One-cycle strobe per synchronised rising edge.
    assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == FullLevel);
        do_read  = rd_en_311 & ~empty;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_write = strobe & (~full | do_read);
        drop     = strobe & full & ~do_read;
    end

    always_ff @(negedge clk_311) begin
        if (reset_311) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in_311};
            prev_q <= sync_q[SYNC_STAGES-1];

            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (do_read) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end

            case ({do_write, do_read})
                2'b10:   level_q <= level_q + LevelOne;
                2'b01:   level_q <= level_q - LevelOne;
                default: level_q <= level_q;
            endcase

            // Set has priority over clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_311) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage carries no reset; empty entries are never visible on ts_out_311.
    // When full with a simultaneous pop, wr_ptr equals rd_ptr: the old head is
    // consumed and its slot becomes the new tail.
    always_ff @(negedge clk_311) begin
        if (!reset_311 && do_write) begin
            mem_q[wr_ptr_q] <= count_in_311;
        end
    end

    assign ts_valid_311   = ~empty;
    assign ts_out_311     = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_level_311 = level_q;
    assign overflow_311   = ovf_q;

endmodule

// File: doc/timestamp_capture_311.md
# timestamp_capture_311

Downstream consumer of the free-running 8-bit up counter. It synchronises an asynchronous event input, detects its rising edge and captures the counter value at that instant into a small first-word-fall-through FIFO. A host drains the FIFO with a read-enable handshake. Lost captures are reported through a sticky overflow flag.

## Interface
Parameters:
- WIDTH, 8, timestamp width; must equal the counter width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- SYNC_STAGES, 2, synchroniser flops on event_in_311; ≥ 2

Ports:
- clk_311  in  1  single clock; all state updates on its falling edge, same edge as the counter
- reset_311  in  1  synchronous, active-high reset, sampled on the falling edge of clk_311
- count_in_311  in  WIDTH  counter value from the up counter
- event_in_311  in  1  asynchronous event; a rising edge requests a capture
- rd_en_311  in  1  pop request; honoured only while ts_valid_311 = 1
- clr_ovf_311  in  1  clears overflow_311
- ts_out_311  out  WIDTH  FIFO head; forced to 0 while ts_valid_311 = 0
- ts_valid_311  out  1  FIFO non-empty
- fifo_level_311  out  log2(DEPTH)+1  number of stored entries, 0..DEPTH
- overflow_311  out  1  sticky; a capture was dropped because the FIFO was full

## Operation
- Synchroniser: event_in_311 passes through SYNC_STAGES flops, then one edge-history flop (prev).
- Capture strobe: combinational `sync_last & ~prev`. It is high for exactly one cycle per synchronised rising edge.
- Write: on the falling edge where the strobe is high, count_in_311 as sampled at that edge is written to the FIFO tail. This is the value before the counter's own update at that edge.
- FIFO is first-word-fall-through:
  - ts_out_311 = mem[rd_ptr] when non-empty.
  - Each pop advances rd_ptr by 1 mod DEPTH.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Level is tracked separately, or derived from extended pointers.
- Boundary rules:
  - Write while level < DEPTH: stored; level +1.
  - Read while ts_valid_311 = 1: popped; level −1.
  - Simultaneous write and read while non-empty (including full): both occur; level unchanged; no overflow.
  - Write while full with no read: capture dropped, FIFO contents untouched, overflow_311 ← 1.
  - rd_en_311 while empty: ignored, including when a write arrives in the same cycle. That entry becomes visible on the next cycle.
  - clr_ovf_311 and a new overflow in the same cycle: set wins, overflow_311 stays 1.
- Counter wrap (0xFF → 0x00) is not special. The raw value is captured; the host handles modular arithmetic.
- Reset values: ts_out_311 = 0, ts_valid_311 = 0, fifo_level_311 = 0, overflow_311 = 0, pointers = 0, synchroniser and prev flops = 0.
- Reset mid-operation: all stored entries are discarded. A synchronous reset on the same edge as a write or read takes priority over both.
- Event held high across reset release: the synchroniser restarts from 0, so exactly one capture occurs after release.

## Timing
- Capture latency: let E1 be the first falling edge sampling event_in_311 = 1.
  - sync_last rises after edge E(SYNC_STAGES); the strobe is high in the following cycle.
  - The write occurs at edge E(SYNC_STAGES+1), i.e. E3 for the default.
  - ts_valid_311 rises just after that edge when the FIFO was empty.
- Read: a pop at edge N updates ts_out_311, ts_valid_311 and fifo_level_311 just after N.
- Event pulse requirements:
  - high for ≥ 1 full clk_311 period, and low for ≥ 1 full period between events, to guarantee one capture each;
  - shorter pulses may be missed, but never produce more than one capture.
- Maximum capture rate: one per 2 cycles.

## Test plan
- Reset: hold reset_311 for 3 edges with event_in_311 toggling -> all outputs 0, no captures, fifo_level_311 = 0.
- Single capture: counter running; raise event_in_311 so that E1 sees it; count_in_311 = 0x2A at edge E3 -> ts_valid_311 = 1, ts_out_311 = 0x2A, level = 1; pulse rd_en_311 one cycle -> ts_valid_311 = 0, ts_out_311 = 0.
- Fill and overflow: 5 events with no reads, counts 0x10, 0x14, 0x18, 0x1C, 0x20 at their write edges -> level = 4, overflow_311 = 1; pop all four -> outputs 0x10, 0x14, 0x18, 0x1C in order; 0x20 absent.
- Full with simultaneous read: FIFO full, write strobe and rd_en_311 on the same edge -> level stays 4, overflow_311 stays 0, new tail value present after three more pops.
- Overflow clear priority: with overflow_311 = 1, assert clr_ovf_311 alone -> 0; then assert clr_ovf_311 on a dropped-write edge -> stays 1.
- Wrap and reset mid-op: capture at count 0xFE and 0x01 -> entries 0xFE, 0x01; assert reset_311 with 2 entries and rd_en_311 high -> level 0, ts_valid_311 0; event held high through release -> exactly one capture afterwards.
